lsu_handshake: RTL
==================

# lsu_handshake

Load/store unit between the core's execute stage and a variable-latency data memory, replacing the zero-latency data path. It accepts one RV32I load or store per transaction from the core over a valid/ready handshake. It converts the transaction into a word-aligned memory request with byte strobes and lane-shifted write data, waits for the memory response, and returns sign- or zero-extended load data to the core. Misaligned accesses, illegal funct3 values and memory timeouts complete with an error flag.

## Interface
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT before an error completion; must be ≥ 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- core_req_valid  in  1  core request valid.
- core_req_ready  out  1  LSU can accept a request; high only in IDLE.
- core_req_we  in  1  1 = store, 0 = load.
- core_req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- core_req_addr  in  ADDR_WIDTH  byte address (ALU result).
- core_req_wdata  in  DATA_WIDTH  store data (rs2), right-aligned.
- core_rsp_valid  out  1  one-cycle completion pulse; the core always accepts.
- core_rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- core_rsp_err  out  1  completion is an error.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_WIDTH  word address, bits [1:0] forced to 0.
- mem_we  out  1  write enable.
- mem_wstrb  out  DATA_WIDTH/8  byte strobes; 0 for loads.
- mem_wdata  out  DATA_WIDTH  lane-shifted write data.
- mem_rsp_valid  in  1  memory response or write acknowledge.
- mem_rsp_rdata  in  DATA_WIDTH  full read word.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: core_req_ready=1. On core_req_valid, latch we, funct3, addr and wdata.
  - Legal and aligned: go to REQ.
  - Otherwise: go to RESP with err=1.
- Legality:
  - Loads: funct3 ∈ {0,1,2,4,5}.
  - Stores: funct3 ∈ {0,1,2}.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte accesses are always aligned.
- REQ: mem_req_valid=1. mem_addr, mem_we, mem_wstrb and mem_wdata are held stable until mem_req_ready=1, then go to WAIT.
- WAIT: on mem_rsp_valid, capture mem_rsp_rdata and go to RESP with err=0. mem_rsp_valid is ignored in every other state.
- RESP: core_rsp_valid=1 for exactly one cycle, then go to IDLE.
- Store strobes, with a = addr[1:0]:
  - SB: 4'b0001<<a.
  - SH: 4'b0011<<a.
  - SW: 4'b1111.
- Store data:
  - SB: wdata[7:0] shifted by 8·a.
  - SH: wdata[15:0] shifted by 8·a.
  - SW: unshifted.
  - Unused lanes are 0.
- Load extraction:
  - Select the byte at 8·a, or the halfword at 8·a, from the captured word.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Timeout:
  - A counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, go to RESP with err=1, rdata=0, and drop mem_req_valid.
  - A late mem_rsp_valid is discarded.
- Simultaneous events: if mem_rsp_valid and the timeout occur in the same cycle, the response wins (err=0).

## Timing
- Reset: state=IDLE, counter=0. All outputs are 0 except core_req_ready=1.
- Reset mid-transaction aborts it with no core response. The memory side must tolerate the abandoned request.
- Registered outputs: mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata, core_rsp_valid, core_rsp_rdata and core_rsp_err.
- Best-case load, accepted at cycle N with mem_req_ready=1 at N+1 and mem_rsp_valid at N+2:
  - mem_req_valid at N+1.
  - core_rsp_valid at N+3.
  - core_req_ready at N+4.
- Error completion (misaligned or illegal): core_rsp_valid at N+1; no memory activity.
- Throughput: one transaction in flight. Minimum 4 cycles per memory access, 2 per error.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF after 3 wait cycles -> rdata=0xDEADBEEF, err=0, mem_addr=0x100, mem_wstrb=0.
- LB at 0x103 with word 0x80FF1234 -> rdata=0xFFFFFF80; LBU at the same address -> 0x00000080; LH at 0x102 -> 0xFFFF80FF.
- SB at 0x201 with wdata 0x000000AB -> mem_wstrb=4'b0010, mem_wdata=0x0000AB00, mem_addr=0x200; SH at 0x202 with 0x1234 -> wstrb=4'b1100, wdata=0x12340000.
- LW at 0x102, then SH at 0x301 -> each gives core_rsp_valid one cycle after accept with err=1; mem_req_valid never asserts.
- mem_req_ready held low for 10 cycles -> request fields stable throughout. Memory never responds -> err=1 after TIMEOUT_CYCLES; a response arriving afterwards is ignored and busy=0.
- rst asserted in WAIT -> next cycle state=IDLE, core_req_ready=1, no core_rsp_valid; a subsequent LW completes normally.

Source files
------------

// File: rtl/lsu_handshake.sv
// Load/store unit: one RV32I load or store per valid/ready handshake, turned into a
// word-aligned strobed memory request, with timeout and error completions.
module lsu_handshake #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req_valid,
  output logic                    core_req_ready,
  input  logic                    core_req_we,
  input  logic [2:0]              core_req_funct3,
  input  logic [ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [DATA_WIDTH-1:0]   core_req_wdata,
  output logic                    core_rsp_valid,
  output logic [DATA_WIDTH-1:0]   core_rsp_rdata,
  output logic                    core_rsp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
  output logic                    busy
);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt;

  logic                  legal, aligned, accept, to_req, fin, fin_err, timeout;
  logic [1:0]            off;
  logic [STRB_W-1:0]     strb_d;
  logic [DATA_WIDTH-1:0] wdata_d, load_d;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  assign off            = core_req_addr[1:0];
  assign core_req_ready = (state == IDLE);
  assign busy           = (state != IDLE);
  assign timeout        = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    legal   = core_req_we ? (core_req_funct3 inside {3'd0, 3'd1, 3'd2})
                          : (core_req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    aligned = 1'b1;
    case (core_req_funct3[1:0])
      2'b01:   aligned = ~core_req_addr[0];
      2'b10:   aligned = (core_req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Strobes and lane-shifted store data; loads issue with no strobes.
  always_comb begin
    strb_d  = '0;
    wdata_d = '0;
    if (core_req_we) begin
      case (core_req_funct3[1:0])
        2'b00: begin
          strb_d  = STRB_W'(4'b0001) << off;
          wdata_d = DATA_WIDTH'(core_req_wdata[7:0]) << {off, 3'b000};
        end
        2'b01: begin
          strb_d  = STRB_W'(4'b0011) << off;
          wdata_d = DATA_WIDTH'(core_req_wdata[15:0]) << {off, 3'b000};
        end
        default: begin
          strb_d  = '1;
          wdata_d = core_req_wdata;
        end
      endcase
    end
  end

  assign byte_v = mem_rsp_rdata[{off_q, 3'b000} +: 8];
  assign half_v = mem_rsp_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    load_d = mem_rsp_rdata;
    case (f3_q)
      3'd0:    load_d = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      3'd1:    load_d = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      3'd4:    load_d = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      3'd5:    load_d = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: load_d = mem_rsp_rdata;
    endcase
    if (we_q) load_d = '0;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    to_req    = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    case (state)
      IDLE: if (core_req_valid) begin
        accept = 1'b1;
        if (legal && aligned) begin
          state_nxt = REQ;
          to_req    = 1'b1;
        end else begin
          state_nxt = RESP;
          fin       = 1'b1;
          fin_err   = 1'b1;
        end
      end
      REQ: if (timeout) begin
        state_nxt = RESP;
        fin       = 1'b1;
        fin_err   = 1'b1;
      end else if (mem_req_ready) begin
        state_nxt = WAIT;
      end
      // A response in the timeout cycle still completes successfully.
      WAIT: if (mem_rsp_valid) begin
        state_nxt = RESP;
        fin       = 1'b1;
      end else if (timeout) begin
        state_nxt = RESP;
        fin       = 1'b1;
        fin_err   = 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      f3_q           <= '0;
      off_q          <= '0;
      we_q           <= 1'b0;
      core_rsp_valid <= 1'b0;
      core_rsp_rdata <= '0;
      core_rsp_err   <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_wstrb      <= '0;
      mem_wdata      <= '0;
    end else begin
      state          <= state_nxt;
      core_rsp_valid <= fin;
      core_rsp_err   <= fin_err;
      core_rsp_rdata <= (fin && !fin_err) ? load_d : '0;
      mem_req_valid  <= (state_nxt == REQ);
      if (to_req) cnt <= '0;
      else if (state == REQ || state == WAIT) cnt <= cnt + CNT_W'(1);
      if (accept) begin
        f3_q  <= core_req_funct3;
        off_q <= off;
        we_q  <= core_req_we;
      end
      if (to_req) begin
        mem_addr  <= {core_req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_we    <= core_req_we;
        mem_wstrb <= strb_d;
        mem_wdata <= wdata_d;
      end
    end
  end
endmodule
